// File: rtl/accel_pkg.sv
// Shared constants and state types for the accelerometer SPI sampler.
package accel_pkg;

  // ADXL345 register map and command bits
  localparam logic [5:0] REG_POWER_CTL = 6'h2D;
  localparam logic [7:0] PWR_MEASURE   = 8'h08;
  localparam logic       CMD_READ      = 1'b1;
  localparam logic       CMD_WRITE     = 1'b0;
  localparam logic       CMD_MB        = 1'b1;
  localparam logic       CMD_SB        = 1'b0;

  // Frame lengths in SCLK bits
  localparam int unsigned INIT_BITS = 16;
  localparam int unsigned READ_BITS = 24;

  // Transmit words are MSB-aligned in a 24-bit field; shorter frames ignore the tail
  localparam logic [23:0] INIT_WORD = {CMD_WRITE, CMD_SB, REG_POWER_CTL, PWR_MEASURE, 8'h00};

  typedef enum logic [2:0] {
    StIdle,
    StInitFrame,
    StGap,
    StWaitTick,
    StReadFrame
  } state_e;

  typedef enum logic [2:0] {
    EngIdle,
    EngSetup,
    EngLow,
    EngHigh,
    EngHold
  } eng_state_e;

  // Multi-byte read command for an axis, followed by two don't-care bytes of zeros
  function automatic logic [23:0] read_word(input logic [5:0] addr);
    return {CMD_READ, CMD_MB, addr, 16'h0000};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-3 SPI frame engine: CS setup, N bits of sclk low/high, CS hold.
// mosi advances on sclk falling edges, miso is captured in the first sclk-high cycle.
module spi_shift_engine
  import accel_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [23:0] tx_i,
  input  logic [4:0]  nbits_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic        mosi_o,
  output logic        done_o,
  output logic [15:0] rx_o
);
  localparam int unsigned    DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  eng_state_e      st_q, st_d;
  logic [DivW-1:0] div_q, div_d;
  logic [4:0]      bit_q, bit_d;
  logic [4:0]      last_q, last_d;
  logic [23:0]     tx_q, tx_d;
  logic [15:0]     rx_q, rx_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic            div_wrap;

  assign div_wrap = (div_q == DivMax);

  // Next-state for the frame sequencer; done_o flags the last cs_n-low cycle
  always_comb begin
    st_d   = st_q;
    div_d  = div_wrap ? '0 : div_q + 1'b1;
    bit_d  = bit_q;
    last_d = last_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    sclk_d = sclk_q;
    cs_n_d = cs_n_q;
    mosi_d = mosi_q;
    done_o = 1'b0;
    unique case (st_q)
      EngIdle: begin
        div_d = '0;
        if (start_i) begin
          st_d   = EngSetup;
          cs_n_d = 1'b0;
          sclk_d = 1'b1;
          tx_d   = tx_i;
          mosi_d = tx_i[23];
          bit_d  = '0;
          last_d = nbits_i - 5'd1;
          rx_d   = '0;
        end
      end
      EngSetup: begin
        if (div_wrap) begin
          st_d   = EngLow;
          sclk_d = 1'b0;
        end
      end
      EngLow: begin
        if (div_wrap) begin
          st_d   = EngHigh;
          sclk_d = 1'b1;
        end
      end
      EngHigh: begin
        if (div_q == '0) begin
          rx_d = {rx_q[14:0], miso_i};
        end
        if (div_wrap) begin
          if (bit_q == last_q) begin
            st_d = EngHold;
          end else begin
            st_d   = EngLow;
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
            tx_d   = {tx_q[22:0], 1'b0};
            mosi_d = tx_q[22];
          end
        end
      end
      EngHold: begin
        if (div_wrap) begin
          st_d   = EngIdle;
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
          done_o = 1'b1;
        end
      end
      default: st_d = EngIdle;
    endcase
  end

  // Engine state and registered SPI pins; reset aborts any frame in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= EngIdle;
      div_q  <= '0;
      bit_q  <= '0;
      last_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      sclk_q <= 1'b1;
      cs_n_q <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      last_q <= last_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      sclk_q <= sclk_d;
      cs_n_q <= cs_n_d;
      mosi_q <= mosi_d;
    end
  end

  assign sclk_o = sclk_q;
  assign cs_n_o = cs_n_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

endmodule

// File: rtl/accel_spi_sampler.sv
// Accelerometer bring-up and periodic single-axis sampler.
// Writes POWER_CTL once, then reads {MSB, LSB} of one axis every SAMPLE_PERIOD cycles.
module accel_spi_sampler
  import accel_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 50,
  parameter int unsigned SAMPLE_PERIOD = 100_000,
  parameter logic [5:0]  AXIS_ADDR     = 6'h32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy
);
  localparam int unsigned      DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned      TickW   = $clog2(SAMPLE_PERIOD);
  localparam logic [DivW-1:0]  DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(SAMPLE_PERIOD - 1);

  state_e           state_q, state_d;
  logic [DivW-1:0]  gap_q, gap_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;
  logic [15:0]      sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;

  logic             eng_start;
  logic [23:0]      eng_tx;
  logic [4:0]       eng_nbits;
  logic             eng_done;
  logic [15:0]      eng_rx;
  logic             in_busy;

  assign eng_tx    = init_done_q ? read_word(AXIS_ADDR) : INIT_WORD;
  assign eng_nbits = init_done_q ? 5'(READ_BITS) : 5'(INIT_BITS);
  assign in_busy   = (state_q == StInitFrame) || (state_q == StReadFrame) || (state_q == StGap);

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk_i   (clk),
    .rst_ni  (reset),
    .start_i (eng_start),
    .tx_i    (eng_tx),
    .nbits_i (eng_nbits),
    .miso_i  (miso),
    .sclk_o  (sclk),
    .cs_n_o  (cs_n),
    .mosi_o  (mosi),
    .done_o  (eng_done),
    .rx_o    (eng_rx)
  );

  // Sequencing, tick generation and the single-entry pending read
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    pending_d   = pending_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    init_done_d = init_done_q;
    eng_start   = 1'b0;

    // Tick counter runs free once the device is powered up
    if (init_done_q) begin
      tick_cnt_d = (tick_cnt_q == TickMax) ? '0 : tick_cnt_q + 1'b1;
      tick_d     = (tick_cnt_q == TickMax);
    end else begin
      tick_cnt_d = '0;
      tick_d     = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        eng_start = 1'b1;
        state_d   = StInitFrame;
      end
      StInitFrame: begin
        if (eng_done) begin
          init_done_d = 1'b1;
          state_d     = StGap;
          gap_d       = '0;
        end
      end
      StReadFrame: begin
        if (eng_done) begin
          // Shift register holds LSB byte then MSB byte
          sample_d = {eng_rx[7:0], eng_rx[15:8]};
          valid_d  = 1'b1;
          state_d  = StGap;
          gap_d    = '0;
        end
      end
      StGap: begin
        if (gap_q == DivMax) begin
          pending_d = 1'b0;
          if (pending_q || tick_q) begin
            eng_start = 1'b1;
            state_d   = StReadFrame;
          end else begin
            state_d = StWaitTick;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StWaitTick: begin
        if (tick_q) begin
          eng_start = 1'b1;
          state_d   = StReadFrame;
        end
      end
      default: state_d = StIdle;
    endcase

    // A tick that did not start a frame is remembered once; extra ones are dropped
    if (tick_q && in_busy && !eng_start) begin
      pending_d = 1'b1;
    end

    busy_d = (state_d == StInitFrame) || (state_d == StReadFrame) || (state_d == StGap);
  end

  // Sampler state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      pending_q   <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      pending_q   <= pending_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign init_done    = init_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_accel_spi_sampler.sv
// Directed bench for accel_spi_sampler with a mode-3 slave model.
// Main instance: CLK_DIV=2, SAMPLE_PERIOD=200. Second instance: SAMPLE_PERIOD=100 (overlapping ticks).
module tb_accel_spi_sampler;

  typedef struct {
    logic [7:0]  lsb;
    logic [7:0]  msb;
    logic [15:0] exp_sample;
  } vec_t;

  vec_t tbl[10];

  logic        clk;
  logic        rst_n, rst2_n;
  logic        sclk, cs_n, mosi, miso;
  logic [15:0] sample;
  logic        sample_valid, init_done, busy;
  logic        sclk2, cs2_n, mosi2, miso2;
  logic [15:0] sample2;
  logic        valid2, init2_done, busy2;

  int checks;
  int failures;

  accel_spi_sampler #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (200),
    .AXIS_ADDR     (6'h32)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .sample       (sample),
    .sample_valid (sample_valid),
    .init_done    (init_done),
    .busy         (busy)
  );

  accel_spi_sampler #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (100),
    .AXIS_ADDR     (6'h32)
  ) dut2 (
    .clk          (clk),
    .reset        (rst2_n),
    .sclk         (sclk2),
    .cs_n         (cs2_n),
    .mosi         (mosi2),
    .miso         (miso2),
    .sample       (sample2),
    .sample_valid (valid2),
    .init_done    (init2_done),
    .busy         (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Mode-3 slave: shift mosi in on rising sclk, drive miso on falling sclk
  logic [23:0] s_tx, s_rx, last_rx;
  int          s_bits = 0, last_bits = 0, frame_cnt = 0, rd_idx = 0;
  logic        s_is_read = 1'b0;

  always @(negedge cs_n) begin
    s_rx      = '0;
    s_bits    = 0;
    s_is_read = init_done;
    s_tx      = init_done ? {8'h00, tbl[rd_idx].lsb, tbl[rd_idx].msb} : 24'h0;
  end
  always @(negedge sclk) if (!cs_n) begin
    miso = s_tx[23];
    s_tx = {s_tx[22:0], 1'b0};
  end
  always @(posedge sclk) if (!cs_n) begin
    s_rx = {s_rx[22:0], mosi};
    s_bits++;
  end
  always @(posedge cs_n) begin
    last_rx   = s_rx;
    last_bits = s_bits;
    frame_cnt++;
    if (s_is_read && rd_idx < 9) rd_idx++;
  end

  // Output monitors, sampled mid-cycle
  int   valid_cyc[16];
  int   nvalid = 0, valid_long = 0, sclk_idle_tog = 0, pre_init_bad = 0;
  int   init_rise_cyc = -1, cs_rise_cyc = -1, frames1 = 0, high_run = 0, min_high = 99999;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_init = 1'b0, prev_valid = 1'b0;

  always @(negedge clk) begin
    if (cs_n && !prev_cs) begin
      cs_rise_cyc = cyc;
      frames1++;
    end
    if (init_done && !prev_init) init_rise_cyc = cyc;
    if (sample_valid) begin
      if (nvalid < 16) valid_cyc[nvalid] = cyc;
      nvalid++;
      if (prev_valid) valid_long++;
    end
    if (cs_n && prev_cs && (sclk != prev_sclk)) sclk_idle_tog++;
    if (!init_done && (sample_valid || sample != 16'h0)) pre_init_bad++;
    if (!cs_n && prev_cs && frames1 > 0 && high_run < min_high) min_high = high_run;
    if (cs_n) high_run++;
    else high_run = 0;
    prev_cs    = cs_n;
    prev_sclk  = sclk;
    prev_init  = init_done;
    prev_valid = sample_valid;
  end

  int   init2_rise = -1, nv2 = 0, nv2_win = 0, frames2 = 0, high2 = 0, min_high2 = 99999;
  int   v2_cyc[2];
  logic prev2_cs = 1'b1, prev2_init = 1'b0;

  always @(negedge clk) begin
    if (init2_done && !prev2_init) init2_rise = cyc;
    if (cs2_n && !prev2_cs) frames2++;
    if (valid2) begin
      if (nv2 < 2) v2_cyc[nv2] = cyc;
      nv2++;
      if (init2_rise >= 0 && (cyc - init2_rise) <= 1000) nv2_win++;
    end
    if (!cs2_n && prev2_cs && frames2 > 0 && high2 < min_high2) min_high2 = high2;
    if (cs2_n) high2++;
    else high2 = 0;
    prev2_cs   = cs2_n;
    prev2_init = init2_done;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int   n, base, rises, nv_before, ok;
  logic prev_s;

  initial begin
    tbl[0] = '{8'h34, 8'h12, 16'h1234};
    tbl[1] = '{8'h00, 8'h80, 16'h8000};
    tbl[2] = '{8'hFF, 8'hFF, 16'hFFFF};
    tbl[3] = '{8'h01, 8'h00, 16'h0001};
    tbl[4] = '{8'h00, 8'h7F, 16'h7F00};
    tbl[5] = '{8'hA5, 8'h5A, 16'h5AA5};
    tbl[6] = '{8'h80, 8'hFF, 16'hFF80};
    tbl[7] = '{8'h55, 8'hAA, 16'hAA55};
    tbl[8] = '{8'h0F, 8'hF0, 16'hF00F};
    tbl[9] = '{8'h7F, 8'h80, 16'h807F};
    checks   = 0;
    failures = 0;
    miso     = 1'b0;
    miso2    = 1'b0;
    rst_n    = 1'b1;
    rst2_n   = 1'b1;
    #1;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", int'(sclk), 1);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_mosi", int'(mosi), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_busy", int'(busy), 0);
    base = frame_cnt;
    @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // Power-up write frame
    n = 0;
    while (frame_cnt == base && n < 500) begin
      @(posedge clk); #1; n++;
    end
    ok = (frame_cnt != base) ? 1 : 0;
    check("init_frame_seen", ok, 1);
    check("init_bits", last_bits, 16);
    check("init_word", int'(last_rx[15:0]), 32'h2D08);
    check("init_done_set", int'(init_done), 1);
    check("init_done_on_cs_rise", init_rise_cyc, cs_rise_cyc);

    // Table of reads: value, command frame, timing
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (nvalid <= k && n < 400) begin
        @(posedge clk); #1; n++;
      end
      ok = (nvalid > k) ? 1 : 0;
      check($sformatf("valid_seen[%0d]", k), ok, 1);
      check($sformatf("sample[%0d]", k), int'(sample), int'(tbl[k].exp_sample));
      check($sformatf("read_cmd[%0d]", k), int'(last_rx), 32'hF20000);
      check($sformatf("read_bits[%0d]", k), last_bits, 24);
      if (k == 0) check("first_valid_latency", valid_cyc[0] - init_rise_cyc, 301);
      else check($sformatf("valid_spacing[%0d]", k), valid_cyc[k] - valid_cyc[k-1], 200);
    end
    check("valid_one_cycle", valid_long, 0);
    check("sclk_idle_toggle", sclk_idle_tog, 0);
    ok = (min_high >= 2) ? 1 : 0;
    check("cs_high_min_2", ok, 1);
    check("no_valid_before_init", pre_init_bad, 0);

    // Reset in the middle of a read
    n = 0;
    while (cs_n && n < 400) begin
      @(posedge clk); #1; n++;
    end
    rises  = 0;
    prev_s = sclk;
    n      = 0;
    while (rises < 10 && n < 400) begin
      @(posedge clk); #1;
      if (sclk && !prev_s) rises++;
      prev_s = sclk;
      n++;
    end
    check("read_sclk_rises", rises, 10);
    check("busy_mid_frame", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", int'(cs_n), 1);
    check("abort_sclk", int'(sclk), 1);
    check("abort_sample", int'(sample), 0);
    check("abort_init_done", int'(init_done), 0);
    check("abort_busy", int'(busy), 0);
    nv_before = nvalid;
    base      = frame_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (frame_cnt == base && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("reinit_bits", last_bits, 16);
    check("reinit_word", int'(last_rx[15:0]), 32'h2D08);
    check("reinit_done", int'(init_done), 1);
    check("no_read_before_reinit", nvalid, nv_before);

    // Overlapping ticks on the SAMPLE_PERIOD=100 instance
    n = 0;
    while ((init2_rise < 0 || (cyc - init2_rise) < 1010) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("ovl_first_valid", v2_cyc[0] - init2_rise, 201);
    check("ovl_pending_valid", v2_cyc[1] - init2_rise, 303);
    check("ovl_valid_count", nv2_win, 8);
    check("ovl_min_gap", min_high2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accel_spi_sampler.md
Name: accel_spi_sampler

Overview:
SPI master that brings up a 3-axis accelerometer (ADXL345 register map) and periodically reads one 16-bit two's-complement axis sample. It sits directly upstream of the 16-tap moving-average smoothing stage. It holds `sample` stable between updates, because the smoothing stage latches its input on its own slow enable.

Parameters:
- CLK_DIV, 50: clk cycles per SCLK half-period; 100 MHz clk gives 1 MHz SCLK. Must be ≥1.
- SAMPLE_PERIOD, 100_000: clk cycles between read starts. Must be ≥ 51*CLK_DIV.
- AXIS_ADDR, 6'h32: low-byte register address of the axis (DATAX0). The MSB register is AXIS_ADDR+1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- sclk, output, 1: SPI clock, mode 3, idles high.
- cs_n, output, 1: SPI chip select, active low.
- mosi, output, 1: SPI data to the device.
- miso, input, 1: SPI data from the device.
- sample, output, 16: last assembled signed sample, {MSB byte, LSB byte}.
- sample_valid, output, 1: one-cycle pulse in the cycle `sample` updates.
- init_done, output, 1: high once the POWER_CTL write has completed.
- busy, output, 1: high while cs_n is low or the inter-frame gap is running.

Behaviour:
- Reset (async assert; state held while reset=0):
  - sclk=1, cs_n=1, mosi=0, sample=0, sample_valid=0, init_done=0, busy=0.
  - FSM goes to IDLE. All counters and the pending flag clear.
  - A reset mid-frame aborts the frame immediately. `sample` is not updated.
- FSM states: IDLE → INIT_FRAME → GAP → WAIT_TICK → READ_FRAME → GAP → WAIT_TICK …
  - IDLE: leaves on the first clk after reset release.
- Frame timing, common to both frame types:
  - CS_SETUP: cs_n low, sclk high, mosi = frame MSB, for CLK_DIV cycles.
  - Then N bits. Each bit is sclk low for CLK_DIV cycles, then sclk high for CLK_DIV cycles.
  - mosi changes only on sclk falling edges; the next bit is driven when sclk goes low.
  - miso is sampled in the clk cycle where sclk rises.
  - CS_HOLD: sclk high for CLK_DIV cycles, then cs_n returns high.
  - GAP: cs_n high for CLK_DIV cycles; busy stays high during GAP.
- INIT_FRAME: N=16, mosi stream 8'h2D then 8'h08 (write, single-byte, POWER_CTL=MEASURE).
  - init_done goes to 1 in the cycle cs_n rises and stays 1 until reset.
- READ_FRAME: N=24.
  - First byte is {1'b1 read, 1'b1 multibyte, AXIS_ADDR}; mosi=0 for bytes 2–3.
  - Byte 2 is the LSB, byte 3 the MSB. Bits are captured MSB-first into a 16-bit shift register.
  - In the cycle cs_n rises: sample ← {byte3, byte2} and sample_valid=1 for exactly one cycle.
- Tick counter:
  - Starts counting when init_done rises.
  - Fires every SAMPLE_PERIOD cycles; the first tick comes SAMPLE_PERIOD cycles after init_done.
  - A tick in WAIT_TICK starts READ_FRAME on the next cycle.
  - A tick while busy sets a single pending flag, which is serviced at GAP exit. Further ticks while pending are dropped.
- Latency: tick → sample_valid = 50*CLK_DIV + 1 cycles. Valid pulses are spaced exactly SAMPLE_PERIOD apart under the parameter constraint.
- Arithmetic:
  - sample is raw two's complement with no sign processing; the downstream stage sign-extends.
  - The tick counter uses $clog2(SAMPLE_PERIOD) bits. The half-period counter wraps to 0 at CLK_DIV-1.

Decomposition:
- Package accel_pkg holds:
  - ADXL constants: REG_POWER_CTL=6'h2D, PWR_MEASURE=8'h08, CMD_READ=1'b1, CMD_MB=1'b1.
  - FSM state enum.
  - Frame length constants: INIT_BITS=16, READ_BITS=24.
- One sub-module, spi_shift_engine:
  - Takes start, a 24-bit tx word, bit count and CLK_DIV.
  - Generates sclk/cs_n/mosi timing including CS_SETUP/CS_HOLD, and shifts in miso.
  - Returns done and the rx word.
- The parent owns init/read sequencing, the tick counter, the pending flag and the sample register.

Test Plan:
All scenarios use CLK_DIV=2, SAMPLE_PERIOD=200 and a behavioural mode-3 slave model.
1. Release reset → cs_n low for one 16-bit frame; slave captures 0x2D, 0x08; init_done=1 when cs_n rises; sample=0, sample_valid=0 throughout.
2. First read, slave returns LSB=0x34, MSB=0x12 → captured command byte 0xF2; sample=16'h1234 with a single one-cycle sample_valid; tick→valid = 101 cycles.
3. Slave returns 0x00/0x80, then 0xFF/0xFF → sample=16'h8000, then 16'hFFFF; no sign mangling.
4. Steady state over 10 reads → sample_valid pulses exactly 200 cycles apart; cs_n high ≥2 cycles between frames; SCLK never toggles while cs_n is high.
5. Assert reset after the 10th rising SCLK edge of a read → cs_n=1 and sclk=1 asynchronously; sample stays at its previous-reset value 0; after release the INIT frame repeats before any read.
6. Force a tick while busy, e.g. SAMPLE_PERIOD=100 with CLK_DIV=2 → pending read starts on GAP exit; no tick is lost for a single overlap; a second overlapping tick is dropped (check valid count).
